// File: rtl/reactor_pkg.sv
// Shared widths, sentinels and types for the adjacency responder.
package reactor_pkg;
   localparam int NODE_IDX_WIDTH  = 10;
   localparam int COUNTER_WIDTH   = 4;
   localparam int EDGE_ADDR_WIDTH = 12;
   localparam int NUM_NODES       = 1 << NODE_IDX_WIDTH;
   localparam int NUM_EDGES       = 1 << EDGE_ADDR_WIDTH;
   localparam int STAGES          = 2;

   localparam logic [NODE_IDX_WIDTH-1:0] NO_NODE    = '1;
   localparam logic [COUNTER_WIDTH-1:0]  MAX_DEGREE = 4'd15;

   typedef enum logic [1:0] {CLEAR, LOAD, SERVE} state_t;

   typedef struct packed {
      logic [EDGE_ADDR_WIDTH-1:0] base;
      logic [COUNTER_WIDTH-1:0]   deg;
   } tbl_entry_t;

   localparam int TBL_W = $bits(tbl_entry_t);
endpackage

// File: rtl/sp_ram.sv
// Synchronous single-port RAM, one-cycle read latency, read-old-on-write.
module sp_ram #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 256,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             i_clk,
   input  logic             i_we,
   input  logic [AW-1:0]    i_addr,
   input  logic [WIDTH-1:0] i_wdata,
   output logic [WIDTH-1:0] o_rdata
);
   logic [WIDTH-1:0] r_mem [DEPTH];

   always_ff @(posedge i_clk) begin
      if (i_we) r_mem[i_addr] <= i_wdata;
      o_rdata <= r_mem[i_addr];
   end
endmodule

// File: rtl/adjacency_responder.sv
// Builds a base/degree table plus edge store from a grouped edge stream, then
// serves successor reads with fixed 2-cycle latency using a per-node cursor.
module adjacency_responder
   import reactor_pkg::*;
(
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      load_valid,
   input  logic [NODE_IDX_WIDTH-1:0] load_src,
   input  logic [NODE_IDX_WIDTH-1:0] load_dst,
   input  logic                      load_done,
   output logic                      load_ready,
   input  logic [NODE_IDX_WIDTH-1:0] node_idx,
   input  logic                      rd_next_node,
   output logic [NODE_IDX_WIDTH-1:0] next_node_idx,
   output logic [COUNTER_WIDTH-1:0]  next_node_counter,
   output logic                      rsp_valid,
   output logic                      busy,
   output logic                      err
);
   state_t                      r_state;
   logic [NODE_IDX_WIDTH-1:0]   r_clr_addr;
   logic [EDGE_ADDR_WIDTH:0]    r_ptr;
   logic [NODE_IDX_WIDTH-1:0]   r_prev_src;
   logic [EDGE_ADDR_WIDTH-1:0]  r_cur_base;
   logic [COUNTER_WIDTH-1:0]    r_cur_deg;
   logic [NUM_NODES-1:0]        r_seen;
   logic [STAGES:0]             r_vld_pipe;
   logic [NODE_IDX_WIDTH-1:0]   r_req_node;
   logic [NODE_IDX_WIDTH-1:0]   r_last_node;
   logic [COUNTER_WIDTH-1:0]    r_last_cursor;
   logic [COUNTER_WIDTH-1:0]    r_last_cnt;
   logic [COUNTER_WIDTH-1:0]    r_s2_cnt;
   logic                        r_s2_empty;
   logic [NODE_IDX_WIDTH-1:0]   r_next_idx;
   logic [COUNTER_WIDTH-1:0]    r_next_cnt;
   logic                        r_err;
   logic                        r_load_ready;

   logic                        w_new_src, w_bad_idx, w_full, w_deg_ovf, w_closed;
   logic                        w_accept, w_drop;
   logic                        w_busy, w_req_acc, w_req_bad;
   logic                        w_restart, w_empty;
   logic [COUNTER_WIDTH-1:0]    w_cursor, w_cnt;
   logic [EDGE_ADDR_WIDTH-1:0]  w_edge_rd_addr;
   logic                        w_tbl_we, w_edge_we;
   logic [NODE_IDX_WIDTH-1:0]   w_tbl_addr;
   logic [EDGE_ADDR_WIDTH-1:0]  w_edge_addr;
   tbl_entry_t                  w_tbl_wdata, w_tbl_rd;
   logic [TBL_W-1:0]            w_tbl_rdata;
   logic [NODE_IDX_WIDTH-1:0]   w_edge_rdata;

   // Load acceptance: any violation drops the edge and leaves group state untouched.
   assign w_new_src = (load_src != r_prev_src);
   assign w_bad_idx = (load_src == NO_NODE) || (load_dst == NO_NODE);
   assign w_full    = r_ptr[EDGE_ADDR_WIDTH];
   assign w_deg_ovf = !w_new_src && (r_cur_deg == MAX_DEGREE);
   assign w_closed  = w_new_src && r_seen[load_src];
   assign w_accept  = load_valid && (r_state == LOAD) &&
                      !(w_bad_idx || w_full || w_deg_ovf || w_closed);
   assign w_drop    = load_valid && (r_state == LOAD) && !w_accept;

   assign w_busy    = r_vld_pipe[0] | r_vld_pipe[1];
   assign w_req_acc = rd_next_node && !w_busy && (r_state == SERVE);
   assign w_req_bad = rd_next_node && !w_req_acc;

   // Stage 1: table entry is valid; pick cursor and launch the edge read.
   assign w_tbl_rd       = tbl_entry_t'(w_tbl_rdata);
   assign w_restart      = (r_req_node != r_last_node) || (r_last_cnt == '0);
   assign w_cursor       = w_restart ? '0 : r_last_cursor + 1'b1;
   assign w_empty        = (w_tbl_rd.deg == '0);
   assign w_cnt          = w_empty ? '0 : w_tbl_rd.deg - 1'b1 - w_cursor;
   assign w_edge_rd_addr = w_tbl_rd.base +
                           {{(EDGE_ADDR_WIDTH-COUNTER_WIDTH){1'b0}}, w_cursor};

   always_comb begin
      w_tbl_we    = 1'b0;
      w_tbl_addr  = node_idx;
      w_tbl_wdata = '0;
      case (r_state)
         CLEAR: begin
            w_tbl_we   = 1'b1;
            w_tbl_addr = r_clr_addr;
         end
         LOAD: begin
            w_tbl_we    = w_accept;
            w_tbl_addr  = load_src;
            w_tbl_wdata = w_new_src ? '{base: r_ptr[EDGE_ADDR_WIDTH-1:0], deg: 4'd1}
                                    : '{base: r_cur_base, deg: r_cur_deg + 1'b1};
         end
         default: ;
      endcase
   end

   assign w_edge_we   = w_accept;
   assign w_edge_addr = (r_state == LOAD) ? r_ptr[EDGE_ADDR_WIDTH-1:0] : w_edge_rd_addr;

   sp_ram #(.WIDTH(TBL_W), .DEPTH(NUM_NODES)) u_tbl (
      .i_clk   (clk),
      .i_we    (w_tbl_we),
      .i_addr  (w_tbl_addr),
      .i_wdata (w_tbl_wdata),
      .o_rdata (w_tbl_rdata)
   );

   sp_ram #(.WIDTH(NODE_IDX_WIDTH), .DEPTH(NUM_EDGES)) u_edges (
      .i_clk   (clk),
      .i_we    (w_edge_we),
      .i_addr  (w_edge_addr),
      .i_wdata (load_dst),
      .o_rdata (w_edge_rdata)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state       <= CLEAR;
         r_clr_addr    <= '0;
         r_ptr         <= '0;
         r_prev_src    <= NO_NODE;
         r_cur_base    <= '0;
         r_cur_deg     <= '0;
         r_vld_pipe    <= '0;
         r_req_node    <= NO_NODE;
         r_last_node   <= NO_NODE;
         r_last_cursor <= '0;
         r_last_cnt    <= '0;
         r_s2_cnt      <= '0;
         r_s2_empty    <= 1'b1;
         r_next_idx    <= NO_NODE;
         r_next_cnt    <= '0;
         r_err         <= 1'b0;
         r_load_ready  <= 1'b0;
      end else begin
         r_vld_pipe <= {r_vld_pipe[STAGES-1:0], w_req_acc};
         case (r_state)
            CLEAR: begin
               r_seen     <= '0;
               r_ptr      <= '0;
               r_prev_src <= NO_NODE;
               r_cur_base <= '0;
               r_cur_deg  <= '0;
               r_clr_addr <= r_clr_addr + 1'b1;
               if (r_clr_addr == NODE_IDX_WIDTH'(NUM_NODES-1)) begin
                  r_state      <= LOAD;
                  r_load_ready <= 1'b1;
               end
            end
            LOAD: begin
               if (w_accept) begin
                  r_ptr <= r_ptr + 1'b1;
                  if (w_new_src) begin
                     r_prev_src       <= load_src;
                     r_cur_base       <= r_ptr[EDGE_ADDR_WIDTH-1:0];
                     r_cur_deg        <= 4'd1;
                     r_seen[load_src] <= 1'b1;
                  end else begin
                     r_cur_deg <= r_cur_deg + 1'b1;
                  end
               end
               if (load_done) begin
                  r_state      <= SERVE;
                  r_load_ready <= 1'b0;
               end
            end
            default: ;
         endcase
         if (w_drop || w_req_bad) r_err <= 1'b1;
         if (w_req_acc) r_req_node <= node_idx;
         if (r_vld_pipe[0]) begin
            r_last_node   <= r_req_node;
            r_last_cursor <= w_cursor;
            r_last_cnt    <= w_cnt;
            r_s2_cnt      <= w_cnt;
            r_s2_empty    <= w_empty;
         end
         if (r_vld_pipe[1]) begin
            r_next_idx <= r_s2_empty ? NO_NODE : w_edge_rdata;
            r_next_cnt <= r_s2_cnt;
         end
      end
   end

   assign load_ready        = r_load_ready;
   assign next_node_idx     = r_next_idx;
   assign next_node_counter = r_next_cnt;
   assign rsp_valid         = r_vld_pipe[STAGES];
   assign busy              = w_busy;
   assign err               = r_err;
endmodule

// File: tb/tb_adjacency_responder.sv
// Directed bench: load phases, cursor walk/wrap, drops, busy/LOAD reads, reset.
module tb_adjacency_responder;
   logic       clk = 1'b0;
   logic       rst_n, load_valid, load_done, rd_next_node;
   logic [9:0] load_src, load_dst, node_idx, next_node_idx;
   logic [3:0] next_node_counter;
   logic       rsp_valid, busy, err, load_ready;
   int         n_tests = 0, n_fail = 0;

   adjacency_responder dut (
      .clk(clk), .rst_n(rst_n),
      .load_valid(load_valid), .load_src(load_src), .load_dst(load_dst),
      .load_done(load_done), .load_ready(load_ready),
      .node_idx(node_idx), .rd_next_node(rd_next_node),
      .next_node_idx(next_node_idx), .next_node_counter(next_node_counter),
      .rsp_valid(rsp_valid), .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; load_valid = 1'b0; load_done = 1'b0; rd_next_node = 1'b0;
      load_src = '0; load_dst = '0; node_idx = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic wait_ready(input string tag);
      int n;
      n = 0;
      for (int k = 1; k <= 1100; k++) begin
         @(posedge clk); #1;
         if (load_ready) begin n = k; break; end
      end
      check(tag, n, 1024);
   endtask

   task automatic load_cyc(input logic v, input logic [9:0] s, input logic [9:0] d, input logic done);
      @(negedge clk);
      load_valid = v; load_src = s; load_dst = d; load_done = done;
      @(posedge clk); #1;
   endtask

   task automatic load_idle();
      @(negedge clk);
      load_valid = 1'b0; load_done = 1'b0;
   endtask

   task automatic do_read(input string tag, input logic [9:0] node,
                          input logic [9:0] exp_idx, input logic [3:0] exp_cnt);
      int lat;
      @(negedge clk);
      node_idx = node; rd_next_node = 1'b1;
      @(posedge clk); #1;
      rd_next_node = 1'b0;
      lat = 0;
      for (int k = 1; k <= 8; k++) begin
         @(posedge clk); #1;
         if (rsp_valid) begin lat = k; break; end
      end
      check({tag, " lat"}, lat, 2);
      check({tag, " idx"}, next_node_idx, exp_idx);
      check({tag, " cnt"}, next_node_counter, exp_cnt);
   endtask

   initial begin
      int pulses;
      logic [9:0] cap_idx;
      logic [3:0] cap_cnt;

      // Session 1: basic load and serve
      do_reset();
      check("rst idx", next_node_idx, 10'h3FF);
      check("rst cnt", next_node_counter, 0);
      check("rst rsp", rsp_valid, 0);
      check("rst busy", busy, 0);
      check("rst err", err, 0);
      check("rst ready", load_ready, 0);
      wait_ready("ready lat1");
      load_cyc(1, 5, 7, 0);
      load_cyc(1, 5, 9, 0);
      load_cyc(1, 5, 2, 0);
      load_cyc(1, 8, 1, 1);
      load_idle();
      check("ready after done", load_ready, 0);
      check("err after load", err, 0);
      do_read("r5a", 5, 7, 2);
      do_read("r5b", 5, 9, 1);
      do_read("r5c", 5, 2, 0);
      do_read("r5wrap", 5, 7, 2);
      do_read("r12", 12, 10'h3FF, 0);
      check("err r12", err, 0);
      do_read("i5", 5, 7, 2);
      do_read("i8", 8, 1, 0);
      do_read("i5b", 5, 7, 2);

      // Second request while busy must be dropped and flagged
      @(negedge clk);
      node_idx = 5; rd_next_node = 1'b1;
      @(posedge clk); #1;
      check("busy T+1", busy, 1);
      pulses = 0; cap_idx = '0; cap_cnt = '0;
      @(posedge clk); #1;
      rd_next_node = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         if (rsp_valid) begin pulses++; cap_idx = next_node_idx; cap_cnt = next_node_counter; end
      end
      check("busy pulses", pulses, 1);
      check("busy idx", cap_idx, 9);
      check("busy cnt", cap_cnt, 1);
      check("busy err", err, 1);

      // Reset in the middle of a read
      @(negedge clk);
      node_idx = 5; rd_next_node = 1'b1;
      @(posedge clk); #1;
      rd_next_node = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk); #1;
      check("mid rst idx", next_node_idx, 10'h3FF);
      check("mid rst cnt", next_node_counter, 0);
      check("mid rst busy", busy, 0);
      check("mid rst err", err, 0);
      check("mid rst rsp", rsp_valid, 0);
      @(posedge clk); #1;
      check("mid rst rsp2", rsp_valid, 0);
      @(negedge clk);
      rst_n = 1'b1;
      wait_ready("ready lat2");

      // Session 2: read during LOAD, NO_NODE drop, empty serve
      @(negedge clk);
      node_idx = 5; rd_next_node = 1'b1;
      @(posedge clk); #1;
      rd_next_node = 1'b0;
      pulses = 0;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         if (rsp_valid) pulses++;
      end
      check("load rd pulses", pulses, 0);
      check("load rd err", err, 1);
      load_cyc(1, 4, 10'h3FF, 0);
      load_cyc(1, 4, 6, 1);
      load_idle();
      do_read("nonode drop", 4, 6, 0);
      do_read("empty5", 5, 10'h3FF, 0);

      // Session 3: degree overflow
      do_reset();
      wait_ready("ready lat3");
      for (int i = 0; i < 16; i++) load_cyc(1, 3, 10'(100 + i), 0);
      load_idle();
      check("ovf err", err, 1);
      load_cyc(0, 0, 0, 1);
      load_idle();
      for (int i = 0; i < 15; i++) do_read($sformatf("n3 %0d", i), 3, 10'(100 + i), 4'(14 - i));
      do_read("n3 wrap", 3, 100, 14);

      // Session 4: reopened source group
      do_reset();
      wait_ready("ready lat4");
      load_cyc(1, 5, 7, 0);
      load_cyc(1, 6, 8, 0);
      load_idle();
      check("grp err0", err, 0);
      load_cyc(1, 5, 9, 1);
      load_idle();
      check("grp err1", err, 1);
      do_read("grp r5", 5, 7, 0);
      do_read("grp r6", 6, 8, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
